// File: rtl/spi_flash_reader.sv
// Sequences SPI master register accesses to stream a byte range out of a SPI NOR
// flash with the READ (0x03) command, delivering the data as a valid/ready stream.
module spi_flash_reader #(
    parameter logic SS_ACTIVE  = 1'b0,
    parameter int   POLL_DELAY = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [23:0] i_flash_addr,
    input  logic [15:0] i_len,
    output logic        o_busy,
    output logic        o_done,
    output logic [7:0]  o_byte,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_spi_addr,
    output logic        o_spi_cs,
    output logic        o_spi_we,
    output logic [7:0]  o_spi_dat,
    input  logic [7:0]  i_spi_dat
);

    localparam int WW = $clog2(POLL_DELAY + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_SEL, S_TX, S_WAIT, S_POLL, S_RD, S_OUT, S_DESEL, S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [23:0] r_addr;
    logic [15:0] r_remaining;
    logic        r_hdr;
    logic [1:0]  r_k;
    logic [WW-1:0] r_wait;
    logic [7:0]  r_byte;
    logic        r_valid;
    logic        r_busy;
    logic        r_done;
    logic [7:0]  w_tx_byte;
    logic        w_spi_cs;
    logic        w_spi_we;
    logic        w_spi_addr;
    logic [7:0]  w_spi_dat;

    // Header is command then address MSB first; data bytes shift a dummy 0x00.
    always_comb begin
        w_tx_byte = 8'h00;
        if (r_hdr) begin
            case (r_k)
                2'd0:    w_tx_byte = 8'h03;
                2'd1:    w_tx_byte = r_addr[23:16];
                2'd2:    w_tx_byte = r_addr[15:8];
                default: w_tx_byte = r_addr[7:0];
            endcase
        end
    end

    always_comb begin
        w_next     = r_state;
        w_spi_cs   = 1'b0;
        w_spi_we   = 1'b0;
        w_spi_addr = 1'b0;
        w_spi_dat  = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next = (i_len == 16'd0) ? S_DONE : S_SEL;
            end
            S_SEL: begin
                w_spi_cs  = 1'b1;
                w_spi_we  = 1'b1;
                w_spi_dat = {7'b0, SS_ACTIVE};
                w_next    = S_TX;
            end
            S_TX: begin
                w_spi_cs   = 1'b1;
                w_spi_we   = 1'b1;
                w_spi_addr = 1'b1;
                w_spi_dat  = w_tx_byte;
                w_next     = S_WAIT;
            end
            S_WAIT: begin
                if (r_wait <= WW'(1)) w_next = S_POLL;
            end
            S_POLL: begin
                w_spi_cs = 1'b1;
                if (!i_spi_dat[7]) w_next = r_hdr ? S_TX : S_RD;
            end
            S_RD: begin
                w_spi_cs   = 1'b1;
                w_spi_addr = 1'b1;
                w_next     = S_OUT;
            end
            S_OUT: begin
                if (i_ready) w_next = (r_remaining == 16'd1) ? S_DESEL : S_TX;
            end
            S_DESEL: begin
                w_spi_cs  = 1'b1;
                w_spi_we  = 1'b1;
                w_spi_dat = {7'b0, ~SS_ACTIVE};
                w_next    = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_addr      <= 24'h0;
            r_remaining <= 16'h0;
            r_hdr       <= 1'b0;
            r_k         <= 2'd0;
            r_wait      <= '0;
            r_byte      <= 8'h00;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (w_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_addr      <= i_flash_addr;
                        r_remaining <= i_len;
                        r_hdr       <= 1'b1;
                        r_k         <= 2'd0;
                    end
                end
                S_TX:   r_wait <= WW'(POLL_DELAY);
                S_WAIT: r_wait <= r_wait - WW'(1);
                S_POLL: begin
                    // Leaving the header phase after the fourth header byte completes.
                    if (!i_spi_dat[7] && r_hdr) begin
                        if (r_k == 2'd3) r_hdr <= 1'b0;
                        r_k <= r_k + 2'd1;
                    end
                end
                S_RD: begin
                    r_byte  <= i_spi_dat;
                    r_valid <= 1'b1;
                end
                S_OUT: begin
                    if (i_ready) begin
                        r_valid     <= 1'b0;
                        r_remaining <= r_remaining - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_byte     = r_byte;
    assign o_valid    = r_valid;
    assign o_spi_cs   = w_spi_cs;
    assign o_spi_we   = w_spi_we;
    assign o_spi_addr = w_spi_addr;
    assign o_spi_dat  = w_spi_dat;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader with a behavioural SPI master + flash model.
module tb_spi_flash_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [23:0] faddr;
    logic [15:0] len;
    logic        busy, done, valid, ready;
    logic [7:0]  obyte;
    logic        spi_addr, spi_cs, spi_we;
    logic [7:0]  spi_wdat, spi_rdat;

    int checks = 0;
    int errors = 0;

    spi_flash_reader #(.SS_ACTIVE(1'b0), .POLL_DELAY(4)) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_flash_addr(faddr),
        .i_len(len), .o_busy(busy), .o_done(done), .o_byte(obyte),
        .o_valid(valid), .i_ready(ready), .o_spi_addr(spi_addr),
        .o_spi_cs(spi_cs), .o_spi_we(spi_we), .o_spi_dat(spi_wdat),
        .i_spi_dat(spi_rdat)
    );

    always #5 clk = ~clk;

    // SPI master + flash model
    logic [7:0] data_tbl[8];
    int         busy_len = 2;
    int         busy_cnt = 0;
    int         tx_idx = 0;
    logic [7:0] rx_reg = 8'h00;
    logic [7:0] mosi_q[$];
    logic [7:0] ctl_q[$];
    logic [7:0] got_q[$];
    int         polls = 0;
    int         done_cnt = 0;
    int         cs_cnt = 0;

    always_comb begin
        spi_rdat = 8'h00;
        if (spi_cs) spi_rdat = spi_addr ? rx_reg : {(busy_cnt > 0), 7'b0};
    end

    always @(posedge clk) begin
        if (rst) begin
            busy_cnt = 0;
            tx_idx   = 0;
        end else begin
            if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
            if (spi_cs && spi_we && !spi_addr) begin
                ctl_q.push_back(spi_wdat);
                if (spi_wdat[0] == 1'b0) tx_idx = 0;
            end
            if (spi_cs && spi_we && spi_addr) begin
                mosi_q.push_back(spi_wdat);
                busy_cnt = busy_len;
                rx_reg   = (tx_idx < 4) ? 8'hFF : data_tbl[(tx_idx - 4) & 7];
                tx_idx   = tx_idx + 1;
            end
            if (spi_cs && !spi_we && !spi_addr) polls++;
            if (valid && ready) got_q.push_back(obyte);
            if (done) done_cnt++;
            if (spi_cs) cs_cnt++;
        end
    end

    task automatic clear_logs();
        mosi_q.delete();
        ctl_q.delete();
        got_q.delete();
    endtask

    task automatic start_xfer(input logic [23:0] a, input logic [15:0] n);
        @(negedge clk);
        start = 1'b1; faddr = a; len = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, input string name);
        int t = 0;
        while (done_cnt == base && t < 3000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (done_cnt == base) begin
            errors++;
            $display("FAIL %s timeout: no o_done after %0d cycles, required one", name, t);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_mosi(input string name, input logic [23:0] a, input int n);
        logic [7:0] exp_q[$];
        exp_q = {8'h03, a[23:16], a[15:8], a[7:0]};
        for (int i = 0; i < n; i++) exp_q.push_back(8'h00);
        checks++;
        if (mosi_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s mosi count: got %0d required %0d", name, mosi_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (mosi_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s mosi[%0d]: got %h required %h", name, i, mosi_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic check_stream(input string name, input int n);
        checks++;
        if (got_q.size() != n) begin
            errors++;
            $display("FAIL %s stream count: got %0d required %0d", name, got_q.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (got_q[i] !== data_tbl[i]) begin
                    errors++;
                    $display("FAIL %s byte[%0d]: got %h required %h", name, i, got_q[i], data_tbl[i]);
                end
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({busy, done, valid, obyte, spi_cs, spi_we, spi_addr, spi_wdat} !== 21'h0) begin
            errors++;
            $display("FAIL %s outputs: busy=%b done=%b valid=%b byte=%h cs=%b we=%b addr=%b dat=%h, required all 0",
                     name, busy, done, valid, obyte, spi_cs, spi_we, spi_addr, spi_wdat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; faddr = 24'h0; len = 16'h0; ready = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset_idle");
    endtask

    task automatic test_basic(input string name);
        int base = done_cnt;
        clear_logs();
        data_tbl[0] = 8'hA5; data_tbl[1] = 8'h5A;
        busy_len = 2; ready = 1'b1;
        start_xfer(24'h123456, 16'd2);
        wait_done(base, name);
        check_mosi(name, 24'h123456, 2);
        check_stream(name, 2);
        checks++;
        if (ctl_q.size() != 2 || ctl_q[0] !== 8'h00 || ctl_q[1] !== 8'h01) begin
            errors++;
            $display("FAIL %s ctl writes: got %0d entries, required 00 then 01", name, ctl_q.size());
        end
        checks++;
        if (done_cnt - base != 1) begin
            errors++;
            $display("FAIL %s done pulses: got %0d required 1", name, done_cnt - base);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy after done: got %b required 0", name, busy);
        end
    endtask

    task automatic test_len0();
        int cs0 = cs_cnt;
        @(negedge clk);
        start = 1'b1; faddr = 24'hFFFFFF; len = 16'd0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL len0 first cycle: busy=%b done=%b required 1 1", busy, done);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL len0 second cycle: busy=%b done=%b required 0 0", busy, done);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (cs_cnt != cs0) begin
            errors++;
            $display("FAIL len0 bus activity: got %0d cs cycles required 0", cs_cnt - cs0);
        end
    endtask

    task automatic test_backpressure();
        int base = done_cnt;
        int t = 0;
        logic [7:0] held;
        int nmosi;
        clear_logs();
        data_tbl[0] = 8'h11; data_tbl[1] = 8'h22; data_tbl[2] = 8'h33;
        busy_len = 2; ready = 1'b0;
        start_xfer(24'h000010, 16'd3);
        while (!valid && t < 500) begin @(negedge clk); t++; end
        held = obyte;
        nmosi = mosi_q.size();
        checks++;
        if (held !== 8'h11 || nmosi != 5) begin
            errors++;
            $display("FAIL bp first valid: byte=%h mosi=%0d required 11 5", held, nmosi);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (obyte !== held || valid !== 1'b1 || mosi_q.size() != nmosi) begin
                errors++;
                $display("FAIL bp stall cycle %0d: byte=%h valid=%b mosi=%0d required %h 1 %0d",
                         i, obyte, valid, mosi_q.size(), held, nmosi);
            end
        end
        ready = 1'b1;
        wait_done(base, "bp");
        check_mosi("bp", 24'h000010, 3);
        check_stream("bp", 3);
    endtask

    task automatic test_start_ignored();
        int base = done_cnt;
        clear_logs();
        data_tbl[0] = 8'hC3; data_tbl[1] = 8'h3C;
        busy_len = 2; ready = 1'b1;
        start_xfer(24'hABCDEF, 16'd2);
        repeat (10) @(negedge clk);
        start_xfer(24'h000000, 16'd5);
        wait_done(base, "ignore");
        check_mosi("ignore", 24'hABCDEF, 2);
        check_stream("ignore", 2);
        checks++;
        if (done_cnt - base != 1) begin
            errors++;
            $display("FAIL ignore done pulses: got %0d required 1", done_cnt - base);
        end
    endtask

    task automatic test_reset_mid();
        int t = 0;
        clear_logs();
        data_tbl[0] = 8'h01; data_tbl[1] = 8'h02; data_tbl[2] = 8'h03;
        busy_len = 2; ready = 1'b1;
        start_xfer(24'h0A0B0C, 16'd3);
        while (mosi_q.size() < 6 && t < 500) begin @(negedge clk); t++; end
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_mid");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (ctl_q.size() != 1 || got_q.size() != 1) begin
            errors++;
            $display("FAIL reset_mid history: ctl=%0d bytes=%0d required 1 1", ctl_q.size(), got_q.size());
        end
        test_basic("after_reset");
    endtask

    task automatic test_slow_poll();
        int base = done_cnt;
        int p0 = polls;
        clear_logs();
        data_tbl[0] = 8'h77; data_tbl[1] = 8'h88;
        busy_len = 14; ready = 1'b1;
        start_xfer(24'h555555, 16'd2);
        wait_done(base, "slow");
        busy_len = 2;
        check_mosi("slow", 24'h555555, 2);
        check_stream("slow", 2);
        checks++;
        if (polls - p0 != 66) begin
            errors++;
            $display("FAIL slow poll count: got %0d required 66", polls - p0);
        end
    endtask

    initial begin
        test_reset();
        test_basic("basic");
        test_len0();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_slow_poll();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
